// File: rtl/wide_stable_bus_synchronizer.sv
// wide_stable_bus_synchronizer: multi-bit synchronizer that commits a word only after it has held stable
module wide_stable_bus_synchronizer #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter int STABLE_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             update,
  output logic             settled
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] PRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 1");
  end
  logic [WIDTH-1:0] sync [STAGES];
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic same, commit;
  assign s = sync[STAGES-1];
  // stability qualifier: restart on any change, count up to saturation, commit on the last step
  always_comb begin
    same = s == cand;
    cnt_nxt = !same ? '0 : (cnt < SAT ? cnt + ONE : cnt);
    commit = same && cnt == PRE;
  end
  // sync chain, qualifier state and registered outputs; everything freezes while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) sync[i] <= RESET_VALUE;
      cand <= RESET_VALUE;
      cnt <= '0;
      out <= RESET_VALUE;
      out_valid <= 1'b0;
      update <= 1'b0;
      settled <= 1'b0;
    end else begin
      update <= 1'b0;
      if (enable) begin
        sync[0] <= in;
        for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
        if (!same) cand <= s;
        cnt <= cnt_nxt;
        settled <= cnt_nxt == SAT;
        if (commit && (!out_valid || cand != out)) begin
          out <= cand;
          out_valid <= 1'b1;
          update <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wide_stable_bus_synchronizer.sv
// tb_wide_stable_bus_synchronizer: scoreboard bench for the stable bus synchronizer
module tb_wide_stable_bus_synchronizer;
  logic clk = 1'b0;
  logic rst, en;
  logic [7:0] din, dout;
  logic ov, upd, st;
  logic ia, oa, va, ua, sa;
  logic [31:0] ib, ob;
  logic vb, ub, sb;
  logic [7:0] ic, oc;
  logic vc, uc, sc;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {logic [7:0] v; int c;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_stable_bus_synchronizer dut (
    .clk(clk), .rst(rst), .enable(en), .in(din),
    .out(dout), .out_valid(ov), .update(upd), .settled(st)
  );
  wide_stable_bus_synchronizer #(.WIDTH(1), .STAGES(3), .STABLE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .enable(en), .in(ia),
    .out(oa), .out_valid(va), .update(ua), .settled(sa)
  );
  wide_stable_bus_synchronizer #(.WIDTH(32), .STAGES(4), .STABLE_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .enable(en), .in(ib),
    .out(ob), .out_valid(vb), .update(ub), .settled(sb)
  );
  wide_stable_bus_synchronizer #(.WIDTH(8), .STAGES(2), .STABLE_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .enable(en), .in(ic),
    .out(oc), .out_valid(vc), .update(uc), .settled(sc)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic expect_commit(input logic [7:0] v, input int c);
    q.push_back('{v: v, c: c});
  endtask

  // monitor: every update pulse must match the next queued commit in value and cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].c < cyc) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_missing: no update by cycle %0d, required out=%h at cycle %0d", cyc, q[0].v, q[0].c);
      void'(q.pop_front());
    end
    if (upd) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: update with out=%h at cycle %0d, required no update", dout, cyc);
      end else begin
        e = q.pop_front();
        if (dout !== e.v || cyc != e.c) begin
          n_bad++;
          $display("FAIL sb_commit: got out=%h at cycle %0d, required out=%h at cycle %0d", dout, cyc, e.v, e.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, l, la, lb, lc;
    rst = 1'b0; en = 1'b1; din = 8'h00; ia = 1'b0; ib = 32'h0; ic = 8'h00;
    tick(2);
    chk("rst_out", dout, 8'h00);
    chk("rst_valid", ov, 0);
    chk("rst_update", upd, 0);
    chk("rst_settled", st, 0);
    rst = 1'b1;
    n = cyc;
    expect_commit(8'h00, n + 3);
    tick(1); chk("init_valid_e1", ov, 0);
    tick(1); chk("init_valid_e2", ov, 0); chk("init_out_e2", dout, 8'h00);
    tick(1); chk("init_valid_e3", ov, 1);
    tick(1); chk("init_settled", st, 1); chk("init_upd_once", upd, 0);
    din = 8'hA5; n = cyc;
    expect_commit(8'hA5, n + 6);
    tick(2); chk("step_settled_e2", st, 1);
    tick(1); chk("step_settled_e3", st, 0); chk("step_out_old", dout, 8'h00);
    tick(3); chk("step_out_new", dout, 8'hA5); chk("step_settled_e6", st, 1);
    tick(1); chk("step_upd_once", upd, 0);
    din = 8'h00; n = cyc;
    expect_commit(8'h00, n + 6);
    tick(7);
    for (int i = 0; i < 20; i++) begin
      din = i[0] ? 8'hF0 : 8'h0F;
      if (i >= 4 && i % 5 == 0) begin
        chk("toggle_settled", st, 0);
        chk("toggle_out", dout, 8'h00);
      end
      tick(1);
    end
    l = cyc - 1;
    expect_commit(8'hF0, l + 6);
    tick(6);
    chk("toggle_commit", dout, 8'hF0);
    din = 8'h3C; n = cyc;
    expect_commit(8'h3C, n + 6);
    tick(7);
    din = 8'hFF;
    tick(1);
    din = 8'h3C;
    tick(2); chk("glitch_settled_dip", st, 0); chk("glitch_out_held", dout, 8'h3C);
    tick(6); chk("glitch_out", dout, 8'h3C); chk("glitch_resettled", st, 1);
    din = 8'h81; n = cyc;
    expect_commit(8'h81, n + 10);
    tick(4); chk("en_mid_settled", st, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("en_frozen_out", dout, 8'h3C);
      chk("en_frozen_settled", st, 0);
    end
    en = 1'b1;
    tick(3); chk("en_commit", dout, 8'h81); chk("en_settled", st, 1);
    din = 8'h55;
    tick(5);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", dout, 8'h00);
    chk("arst_valid", ov, 0);
    chk("arst_update", upd, 0);
    chk("arst_settled", st, 0);
    din = 8'h00;
    tick(1);
    rst = 1'b1; n = cyc;
    expect_commit(8'h00, n + 3);
    tick(3); chk("arst_recommit_valid", ov, 1); chk("arst_recommit_out", dout, 8'h00);
    tick(4); chk("arst_no_55", dout, 8'h00);
    ia = 1'b1; ib = 32'hDEADBEEF; ic = 8'h5A; n = cyc;
    la = 0; lb = 0; lc = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (ua && la == 0) la = cyc - n;
      if (ub && lb == 0) lb = cyc - n;
      if (uc && lc == 0) lc = cyc - n;
    end
    chk("sweep_lat_w1_s3_c1", la, 5);
    chk("sweep_lat_w32_s4_c4", lb, 9);
    chk("sweep_lat_w8_s2_c1", lc, 4);
    chk("sweep_out_w1", oa, 1);
    chk("sweep_out_w32", ob, 32'hDEADBEEF);
    chk("sweep_out_w8", oc, 8'h5A);
    chk("sweep_settled", {sa, sb, sc}, 3'b111);
    tick(2);
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
